bram_dp: RTL and testbench
==========================

BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 8000, number of words.
- ADDR_W, 32, address port width.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- TAP_STRIDE, 4, word spacing of debug taps.
- TAP_COUNT, 6, number of debug taps.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clka, in, 1, single clock; all ports are synchronous to it.
- rsta_n, in, 1, asynchronous active-low reset.
- clr, in, 1, single-cycle pulse that starts a runtime zero-fill.
- ena, in, 1, port A enable.
- wea, in, DATA_W/8, port A byte write enables.
- addra, in, ADDR_W, port A word address.
- dina, in, DATA_W, port A write data.
- douta, out, DATA_W, port A read data.
- vala, out, 1, douta valid strobe.
- enb, in, 1, port B read enable (port B is read-only).
- addrb, in, ADDR_W, port B word address.
- doutb, out, DATA_W, port B read data.
- valb, out, 1, doutb valid strobe.
- busy, out, 1, zero-fill in progress.
- oor_err, out, 1, sticky out-of-range access flag.
- taps, out, TAP_COUNT*DATA_W, debug word snapshots.

Function
REQ-003 The FSM SHALL have three states: CLEAR, READY and FLUSH. Reset enters CLEAR. CLEAR moves to READY after DEPTH fill cycles. In READY, clr=1 moves to FLUSH. FLUSH moves to CLEAR on the next cycle.
REQ-004 In CLEAR the block SHALL write zero to address cnt and increment cnt from 0 to DEPTH-1, one word per cycle, holding busy=1.
REQ-005 In FLUSH the block SHALL drain the read pipeline, reset cnt to 0 and hold busy=1.
REQ-006 While busy=1, ena and enb SHALL be ignored: no writes occur and no valid strobes are raised.
REQ-007 In READY, a port A write SHALL update byte k of mem[addra] when ena=1 and wea[k]=1; bytes with wea[k]=0 are unchanged.
REQ-008 Port A SHALL be write-first: douta returns the merged post-write word.
REQ-009 Port B SHALL return the pre-write word when addrb equals a same-cycle port A write address.
REQ-010 Read data and its valid strobe (vala/valb) SHALL appear READ_LAT cycles after the enabled request; the valid strobe pulses high for exactly one cycle per request.
REQ-011 douta and doutb SHALL hold their last value when no new read completes.
REQ-012 An address >= DEPTH SHALL be treated as out of range:
- the write is discarded;
- the read returns 0 with its valid strobe still raised;
- oor_err is set.
REQ-013 Address wrap SHALL NOT occur; out-of-range handling (REQ-012) applies instead.
REQ-014 oor_err SHALL stay set until reset or clr.
REQ-015 A clr arriving while busy=1 SHALL be ignored.
REQ-016 The block SHALL accept back-to-back requests every cycle on both ports in READY.

Reset
REQ-017 While rsta_n=0 the block SHALL drive douta=0, doutb=0, vala=0, valb=0, oor_err=0, taps=0 and busy=1, with cnt=0 and state CLEAR.
REQ-018 Release of rsta_n SHALL start the zero-fill; READY is reached DEPTH cycles after release.
REQ-019 Reset asserted mid-CLEAR or mid-access SHALL abort the operation and restart the fill from address 0.

Configuration
REQ-020 With macro BRAM_DP_DEBUG_TAP_EN defined, each cycle taps slice i SHALL register mem[i*TAP_STRIDE], for i = 0 to TAP_COUNT-1.
REQ-021 Without BRAM_DP_DEBUG_TAP_EN, taps SHALL be tied to 0 and no tap registers are built.

Verification
REQ-022 Reset, DEPTH=16: release rsta_n -> busy=1 for exactly 16 cycles, then 0; reads of all 16 addresses return 0.
REQ-023 Byte-enable write, READ_LAT=1: write 0xAABBCCDD to address 3 with wea=4'b1111, then 0x11223344 with wea=4'b0101 -> read of address 3 returns 0xAA22CC44, with vala high one cycle after the request.
REQ-024 Collision: port A writes 0x5 to address 7 (old value 0x9) while port B reads address 7 in the same cycle -> douta=0x5, doutb=0x9.
REQ-025 READ_LAT=2, continuous reads of addresses 0,1,2,3 -> data appears on cycles 2,3,4,5 with valb high on each of those cycles.
REQ-026 Out of range, DEPTH=16: write to address 16 -> oor_err=1 and no memory word changes; read of address 20 -> valb=1 with doutb=0; clr -> oor_err=0 and busy=1 for 17 cycles (1 FLUSH + 16 CLEAR).
REQ-027 With BRAM_DP_DEBUG_TAP_EN: write 0x77 to address 8 -> taps slice 2 equals 0x77 two cycles later. Without the macro, taps stays 0.

Source files
------------

// File: rtl/bram_dp_if.sv
// bram_dp_if -- bus bundle for the bram_dp dual-port block RAM.
//
// Carries every bram_dp port except the clock and reset:
//   clr            runtime zero-fill request (single-cycle pulse)
//   ena/wea/addra/dina/douta/vala   port A (read/write, byte enables)
//   enb/addrb/doutb/valb            port B (read-only)
//   busy           zero-fill / flush in progress
//   oor_err        sticky out-of-range access flag
//   taps           debug word snapshots (TAP_COUNT words)
//
// master: the requester side (drives requests, observes responses).
// slave : the memory side (bram_dp itself).
interface bram_dp_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TAP_COUNT = 6
);
    logic                        clr;
    logic                        ena;
    logic [DATA_W/8-1:0]         wea;
    logic [ADDR_W-1:0]           addra;
    logic [DATA_W-1:0]           dina;
    logic [DATA_W-1:0]           douta;
    logic                        vala;
    logic                        enb;
    logic [ADDR_W-1:0]           addrb;
    logic [DATA_W-1:0]           doutb;
    logic                        valb;
    logic                        busy;
    logic                        oor_err;
    logic [TAP_COUNT*DATA_W-1:0] taps;

    modport master (
        output clr, ena, wea, addra, dina, enb, addrb,
        input  douta, vala, doutb, valb, busy, oor_err, taps
    );

    modport slave (
        input  clr, ena, wea, addra, dina, enb, addrb,
        output douta, vala, doutb, valb, busy, oor_err, taps
    );
endinterface

// File: rtl/bram_dp.sv
// bram_dp -- dual-port block RAM with runtime zero-fill.
//
// Port A is read/write with byte enables and write-first read data; port B
// is read-only and returns the pre-write word on a same-cycle collision.
// Read data and a one-cycle valid strobe appear READ_LAT (1 or 2) cycles
// after each enabled request; outputs hold between completions.
// Addresses >= DEPTH never wrap: writes are dropped, reads return 0 (still
// strobed) and the sticky oor_err flag is raised until reset or clr.
// After reset release, and after an accepted clr (via one FLUSH cycle),
// the memory is zero-filled one word per cycle while busy=1; requests are
// ignored during that time.
//
// Ports:
//   clka    clock, all interface signals are synchronous to it
//   rsta_n  asynchronous active-low reset
//   bus     bram_dp_if.slave (clr, port A, port B, busy, oor_err, taps)
//
// Optional feature: define BRAM_DP_DEBUG_TAP_EN to register
// mem[i*TAP_STRIDE] into taps slice i every cycle; otherwise taps is 0.
module bram_dp #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 8000,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned TAP_STRIDE = 4,
    parameter int unsigned TAP_COUNT  = 6
) (
    input  logic       clka,
    input  logic       rsta_n,
    bram_dp_if.slave   bus
);
    localparam int unsigned       NB       = DATA_W / 8;
    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              oor_q, oor_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              a_req, b_req, a_oor, b_oor, keep;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [DATA_W-1:0] a_old, a_merge, a_rdata, b_rdata;

    logic              s1_va_q, s1_va_d, s1_vb_q, s1_vb_d;
    logic [DATA_W-1:0] s1_da_q, s1_da_d, s1_db_q, s1_db_d;
    logic              fin_va, fin_vb;
    logic [DATA_W-1:0] fin_da, fin_db;
    logic              vala_q, vala_d, valb_q, valb_d;
    logic [DATA_W-1:0] douta_q, douta_d, doutb_q, doutb_d;

    // Request decode and read data (port A merged write-first, port B pre-write).
    always_comb begin
        a_req   = bus.ena && (state_q == READY);
        b_req   = bus.enb && (state_q == READY);
        a_oor   = (bus.addra >= DEPTH_A);
        b_oor   = (bus.addrb >= DEPTH_A);
        a_idx   = bus.addra[IDX_W-1:0];
        b_idx   = bus.addrb[IDX_W-1:0];
        a_old   = mem_q[a_idx];
        a_merge = a_old;
        for (int unsigned k = 0; k < NB; k++) begin
            if (bus.wea[k]) begin
                a_merge[k*8 +: 8] = bus.dina[k*8 +: 8];
            end
        end
        a_rdata = a_oor ? '0 : a_merge;
        b_rdata = b_oor ? '0 : mem_q[b_idx];
    end

    // Single write port shared by the zero-fill and port A.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (a_req && !a_oor && (|bus.wea)) begin
            mem_we    = 1'b1;
            mem_waddr = a_idx;
            mem_wdata = a_merge;
        end
    end

    always_ff @(posedge clka) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM. clr is only honoured in READY and takes priority over a
    // same-cycle out-of-range access when clearing oor_err.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (bus.clr) begin
                    state_d = FLUSH;
                    oor_d   = 1'b0;
                end else if ((a_req && a_oor) || (b_req && b_oor)) begin
                    oor_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != READY);
    end

    // Read pipeline. Reads issued in the cycle clr is taken are dropped so
    // no strobe ever surfaces once the block has left READY.
    always_comb begin
        keep    = (state_d == READY);
        s1_va_d = a_req && keep;
        s1_vb_d = b_req && keep;
        s1_da_d = a_rdata;
        s1_db_d = b_rdata;
        if (READ_LAT == 2) begin
            fin_va = s1_va_q;
            fin_vb = s1_vb_q;
            fin_da = s1_da_q;
            fin_db = s1_db_q;
        end else begin
            fin_va = s1_va_d;
            fin_vb = s1_vb_d;
            fin_da = a_rdata;
            fin_db = b_rdata;
        end
        vala_d  = fin_va;
        valb_d  = fin_vb;
        douta_d = fin_va ? fin_da : douta_q;
        doutb_d = fin_vb ? fin_db : doutb_q;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            oor_q   <= 1'b0;
            s1_va_q <= 1'b0;
            s1_vb_q <= 1'b0;
            s1_da_q <= '0;
            s1_db_q <= '0;
            vala_q  <= 1'b0;
            valb_q  <= 1'b0;
            douta_q <= '0;
            doutb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            oor_q   <= oor_d;
            s1_va_q <= s1_va_d;
            s1_vb_q <= s1_vb_d;
            s1_da_q <= s1_da_d;
            s1_db_q <= s1_db_d;
            vala_q  <= vala_d;
            valb_q  <= valb_d;
            douta_q <= douta_d;
            doutb_q <= doutb_d;
        end
    end

    assign bus.douta   = douta_q;
    assign bus.vala    = vala_q;
    assign bus.doutb   = doutb_q;
    assign bus.valb    = valb_q;
    assign bus.busy    = busy_q;
    assign bus.oor_err = oor_q;

`ifdef BRAM_DP_DEBUG_TAP_EN
    logic [TAP_COUNT*DATA_W-1:0] taps_q, taps_d;

    // Taps beyond the end of the memory read as zero.
    always_comb begin
        taps_d = '0;
        for (int unsigned i = 0; i < TAP_COUNT; i++) begin
            if (i * TAP_STRIDE < DEPTH) begin
                taps_d[i*DATA_W +: DATA_W] = mem_q[IDX_W'(i * TAP_STRIDE)];
            end
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign bus.taps = taps_q;
`else
    assign bus.taps = '0;
`endif
endmodule

// File: tb/tb_bram_dp.sv
module tb_bram_dp;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned TC    = 6;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk    = 1'b0;
    logic rsta_n = 1'b1;
    int   cyc_n  = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t          q [4][$];
    logic [DW-1:0] last [4];
    logic [DW-1:0] exp_mem [DEPTH];
    string         sname [4] = '{"u1.a", "u1.b", "u2.a", "u2.b"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    bram_dp_if #(.DATA_W(DW), .ADDR_W(AW), .TAP_COUNT(TC)) if1 ();
    bram_dp_if #(.DATA_W(DW), .ADDR_W(AW), .TAP_COUNT(TC)) if2 ();

    bram_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1),
              .TAP_STRIDE(4), .TAP_COUNT(TC)) u1 (
        .clka(clk), .rsta_n(rsta_n), .bus(if1.slave)
    );

    bram_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2),
              .TAP_STRIDE(4), .TAP_COUNT(TC)) u2 (
        .clka(clk), .rsta_n(rsta_n), .bus(if2.slave)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a stream strobes valid.
    task automatic mon(input int s, input logic v, input logic [DW-1:0] d, input int lat);
        exp_t e;
        if (v) begin
            if (q[s].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected valid: got data %0h expected no strobe", sname[s], d);
            end else begin
                e = q[s].pop_front();
                chk({sname[s], " data"}, 256'(d), 256'(e.data));
                chk({sname[s], " latency"}, 256'(cyc_n - e.cyc), 256'(lat));
                last[s] = e.data;
            end
        end else begin
            chk({sname[s], " hold"}, 256'(d), 256'(last[s]));
        end
    endtask

    always @(negedge clk) begin
        if (rsta_n) begin
            mon(0, if1.vala, if1.douta, 1);
            mon(1, if1.valb, if1.doutb, 1);
            mon(2, if2.vala, if2.douta, 2);
            mon(3, if2.valb, if2.doutb, 2);
        end
    end

    task automatic setin(input logic c, input logic ea, input logic [3:0] wa,
                         input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic eb, input logic [AW-1:0] ab);
        if1.clr = c;  if1.ena = ea; if1.wea = wa; if1.addra = aa; if1.dina = da;
        if1.enb = eb; if1.addrb = ab;
        if2.clr = c;  if2.ena = ea; if2.wea = wa; if2.addra = aa; if2.dina = da;
        if2.enb = eb; if2.addrb = ab;
    endtask

    // One request cycle on both DUTs; expected responses go to the scoreboard.
    task automatic drive(input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic [DW-1:0] xa,
                         input logic eb, input logic [AW-1:0] ab, input logic [DW-1:0] xb);
        exp_t e;
        @(posedge clk); #1;
        setin(1'b0, ea, wa, aa, da, eb, ab);
        e.cyc = cyc_n;
        if (ea) begin
            e.data = xa;
            q[0].push_back(e);
            q[2].push_back(e);
        end
        if (eb) begin
            e.data = xb;
            q[1].push_back(e);
            q[3].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            setin(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        end
    endtask

    task automatic count_busy(output int n, output logic vseen);
        n = 0;
        vseen = 1'b0;
        forever begin
            @(negedge clk);
            if (!if1.busy) break;
            vseen = vseen | if1.vala | if1.valb | if2.vala | if2.valb;
            n++;
            if (n > 200) break;
        end
    endtask

    task automatic reread();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, 4'h0, AW'(i), '0, exp_mem[i],
                  1'b1, AW'(int'(DEPTH) - 1 - i), exp_mem[int'(DEPTH) - 1 - i]);
        end
        idle(3);
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, " u1 outs"}, 256'({if1.douta, if1.doutb, if1.vala, if1.valb, if1.oor_err, if1.busy}),
            256'({64'h0, 4'b0001}));
        chk({nm, " u2 outs"}, 256'({if2.douta, if2.doutb, if2.vala, if2.valb, if2.oor_err, if2.busy}),
            256'({64'h0, 4'b0001}));
        chk({nm, " taps"}, 256'({if1.taps, if2.taps}), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic vs;
        foreach (last[i]) last[i] = '0;
        foreach (exp_mem[i]) exp_mem[i] = '0;
        setin(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);

        // Reset state and fill length after release.
        #2 rsta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("reset");
        @(posedge clk); #1;
        rsta_n = 1'b1;
        count_busy(n, vs);
        chk("fill busy cycles", 256'(n), 256'(16));
        chk("u2 ready", 256'(if2.busy), '0);
        reread();

        // Byte-enable merge, write-first.
        drive(1'b1, 4'hF, 32'd3, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, '0, '0);
        drive(1'b1, 4'h5, 32'd3, 32'h11223344, 32'hAA22CC44, 1'b0, '0, '0);
        drive(1'b1, 4'h0, 32'd3, 32'h0,        32'hAA22CC44, 1'b0, '0, '0);
        exp_mem[3] = 32'hAA22CC44;

        // Collision: port B sees the pre-write word.
        drive(1'b1, 4'hF, 32'd7, 32'h9, 32'h9, 1'b0, '0, '0);
        drive(1'b1, 4'hF, 32'd7, 32'h5, 32'h5, 1'b1, 32'd7, 32'h9);
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd7, 32'h5);
        exp_mem[7] = 32'h5;

        // Back-to-back port B reads.
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd0, 32'h0);
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd1, 32'h0);
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd2, 32'h0);
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd3, 32'hAA22CC44);

        // Debug tap on address 8 (slice 2).
        drive(1'b1, 4'hF, 32'd8, 32'h77, 32'h77, 1'b0, '0, '0);
        exp_mem[8] = 32'h77;
        idle(2);
`ifdef BRAM_DP_DEBUG_TAP_EN
        chk("tap slice 2", 256'(if1.taps[2*DW +: DW]), 256'(32'h77));
`else
        chk("taps tied off", 256'({if1.taps, if2.taps}), '0);
`endif

        // Out-of-range: no wrap, zero read data, sticky flag.
        chk("oor clear before", 256'({if1.oor_err, if2.oor_err}), '0);
        drive(1'b1, 4'hF, 32'd16, 32'hDEADBEEF, 32'h0, 1'b0, '0, '0);
        idle(1);
        chk("oor set by write", 256'({if1.oor_err, if2.oor_err}), 256'(2'b11));
        drive(1'b0, 4'h0, '0, '0, '0, 1'b1, 32'd20, 32'h0);
        drive(1'b1, 4'h0, 32'h10000003, '0, 32'h0, 1'b1, 32'd15, 32'h0);
        idle(2);
        chk("oor sticky", 256'({if1.oor_err, if2.oor_err}), 256'(2'b11));
        reread();

        // clr: flush + refill; requests and a repeated clr are ignored while busy.
        @(posedge clk); #1;
        setin(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        chk("oor cleared by clr", 256'({if1.oor_err, if2.oor_err}), '0);
        setin(1'b1, 1'b1, 4'hF, 32'd1, 32'hFF, 1'b1, 32'd1);
        count_busy(n, vs);
        setin(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        chk("clr busy cycles", 256'(n), 256'(17));
        chk("no strobe while busy", 256'(vs), '0);
        foreach (exp_mem[i]) exp_mem[i] = '0;
        reread();
        chk("oor after refill", 256'({if1.oor_err, if2.oor_err}), '0);

        // Reset in the middle of a fill restarts it from address 0.
        @(posedge clk); #1;
        setin(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        setin(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
        repeat (5) @(posedge clk);
        #2 rsta_n = 1'b0;
        foreach (last[i]) last[i] = '0;
        #1;
        rst_chk("mid-fill reset");
        @(posedge clk); #1;
        rsta_n = 1'b1;
        count_busy(n, vs);
        chk("refill after reset", 256'(n), 256'(16));
        drive(1'b1, 4'hF, 32'd15, 32'h12345678, 32'h12345678, 1'b0, '0, '0);
        drive(1'b1, 4'h0, 32'd15, '0, 32'h12345678, 1'b1, 32'd15, 32'h12345678);
        idle(4);

        for (int s = 0; s < 4; s++) begin
            chk({sname[s], " scoreboard drained"}, 256'(q[s].size()), '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
